mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the instruction-fetch port and the data (load/store) port.
//  One grant per free slot; fixed-latency read return is routed back to the owning requester.
//  Sits between the fetch/ifid stage, the execute-stage data access, and the memory macro.
//  Stalls fetch (via gnt low) so the hazard logic can hold the pc/ifid.
// PARAMETERS
//  ADDR_W        32  address width, byte addressed
//  DATA_W        32  data width
//  MEM_LATENCY   1   cycles from mem_en to valid mem_rdata; legal range 1..7
//  STARVE_LIMIT  4   consecutive fetch losses before fetch is forced to win; legal range 1..15
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  if_req     in   1       fetch request; held with if_addr stable until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       fetch accepted this cycle
//  if_rvalid  out  1       fetch read data valid
//  if_rdata   out  DATA_W  fetch read data
//  d_req      in   1       data request; held with its fields stable until d_gnt
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       data accepted this cycle
//  d_rvalid   out  1       load data valid (never asserted for stores)
//  d_rdata    out  DATA_W  load data
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en
// BEHAVIOUR
//  - Reset (reset low, asynchronous): state IDLE, lat_cnt 0, starve_cnt 0, response pipe cleared.
//    All gnt/rvalid/mem_en/mem_we are 0; data outputs are 0.
//  - Slot free when state is IDLE, or BUSY with lat_cnt == MEM_LATENCY-1 (the final busy cycle).
//  - Grant decision is combinational in a free-slot cycle T:
//    - Only one req: that port wins.
//    - Both reqs: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
//  - Winner: gnt=1 in T; mem_en=1 in T; mem_we/addr/wdata taken from the winner; fetch always mem_we=0.
//  - Loser: sees gnt=0 and must hold its request.
//  - FSM: IDLE -> BUSY on grant when MEM_LATENCY>1; BUSY stays until lat_cnt reaches MEM_LATENCY-1.
//    From that final cycle: back to IDLE with no grant, or re-arm BUSY on a new grant.
//  - With MEM_LATENCY==1 the FSM never leaves IDLE; back-to-back grants every cycle.
//  - Read return: an owner tag (IF / D / NONE) is shifted MEM_LATENCY deep.
//    At T+MEM_LATENCY the owner's rvalid=1 and rdata=mem_rdata.
//    Stores carry tag NONE, so no rvalid is produced.
//  - rdata holds its last value when rvalid=0.
//  - starve_cnt:
//    - +1 (saturating at STARVE_LIMIT) in a free slot where if_req=1 and data is granted.
//    - Cleared when fetch is granted or when if_req=0.
//    - Otherwise held.
//  - Reset mid-access: the in-flight response is dropped (no rvalid after reset releases).
//  - A req that drops without a grant is legal (flush); no state effect beyond the starve_cnt rule.
// CONFIGURATION
//  MEM_PORT_ARBITER_PERF_EN defined: adds output ports conflict_cnt[15:0] and fetch_stall_cnt[15:0].
//  - conflict_cnt: +1 per free slot with both reqs asserted.
//  - fetch_stall_cnt: +1 per cycle with if_req=1 and if_gnt=0.
//  - Both saturate at 16'hFFFF and are reset to 0.
//  Undefined: these ports and counters do not exist; arbitration is identical either way.
// STRUCTURE
//  Package mem_arb_pkg holds:
//  - typedef enum {ARB_IDLE, ARB_BUSY} arb_state_t
//  - typedef enum logic[1:0] {OWN_NONE, OWN_IF, OWN_D} arb_owner_t
//  - localparam MAX_MEM_LATENCY = 7
//  Sub-module mem_arb_resp_pipe: MEM_LATENCY-deep arb_owner_t shift register with async active-low reset.
//  Grant logic, FSM and starve counter stay in mem_port_arbiter.
// TESTING
//  1. Fetch only, MEM_LATENCY=1, if_req=1 with addr 0,4,8: if_gnt every cycle; if_rvalid one cycle
//     after each grant carrying mem[0], mem[4], mem[8]; d_rvalid stays 0.
//  2. Both reqs every cycle, STARVE_LIMIT=4: grant order D,D,D,D,IF,D,D,D,D,IF...;
//     starve_cnt returns to 0 after each IF grant.
//  3. MEM_LATENCY=3, load 0x100 then fetch 0x0: d_gnt at T; if_gnt no earlier than T+2;
//     d_rvalid at T+3 with mem[0x100]; if_rvalid at T+5.
//  4. Store d_we=1 addr 0x40 wdata 0xDEADBEEF, then load 0x40: mem_we=1 only on the store grant;
//     no d_rvalid for the store; the load returns 0xDEADBEEF.
//  5. reset pulled low while a load is in flight (MEM_LATENCY=3): all outputs 0 immediately;
//     no rvalid after release; the next request is granted in the first cycle after release.
//  6. With PERF_EN, both reqs for 10 cycles at MEM_LATENCY=1: conflict_cnt=10; fetch_stall_cnt=8.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int MAX_MEM_LATENCY = 7;
    localparam int LAT_W           = $clog2(MAX_MEM_LATENCY + 1);
    localparam int STARVE_W        = 4;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} arb_owner_t;

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// Owner-tag delay line: the tag entering with a grant emerges DEPTH cycles later,
// aligned with the memory read data.
module mem_arb_resp_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  arb_owner_t tag_in,
    output arb_owner_t tag_out
);

    logic [DEPTH-1:0][1:0] pipe_q;
    logic [DEPTH-1:0][1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = arb_owner_t'(pipe_q[DEPTH-1]);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, with fetch
// anti-starvation. MEM_PORT_ARBITER_PERF_EN adds conflict/stall counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       fetch_stall_cnt
`endif
);

    localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state_q, state_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                slot_free, if_win, d_win;
    arb_owner_t          tag_in, tag_out;

    // Gating with reset keeps every grant and strobe low while reset is held.
    always_comb begin
        slot_free = reset && ((state_q == ARB_IDLE) || (lat_cnt_q == LAT_LAST));
        if_win    = slot_free && if_req && (!d_req || (starve_cnt_q == STARVE_MAX));
        d_win     = slot_free && d_req && !if_win;
    end

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        if (state_q == ARB_BUSY) begin
            if (lat_cnt_q != LAT_LAST) begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end else begin
                state_d   = ARB_IDLE;
                lat_cnt_d = '0;
            end
        end
        // lat_cnt counts cycles since the grant; the slot reopens at MEM_LATENCY-1.
        if ((if_win || d_win) && (MEM_LATENCY > 1)) begin
            state_d   = ARB_BUSY;
            lat_cnt_d = LAT_W'(1);
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_win) begin
            starve_cnt_d = '0;
        end else if (d_win && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    always_comb begin
        tag_in = OWN_NONE;
        if (if_win) begin
            tag_in = OWN_IF;
        end else if (d_win && !d_we) begin
            tag_in = OWN_D;
        end
    end

    mem_arb_resp_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_resp_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_comb begin
        if_rvalid  = (tag_out == OWN_IF);
        d_rvalid   = (tag_out == OWN_D);
        if_rdata   = if_rvalid ? mem_rdata : if_rdata_q;
        d_rdata    = d_rvalid ? mem_rdata : d_rdata_q;
        if_rdata_d = if_rdata;
        d_rdata_d  = d_rdata;
    end

    always_comb begin
        if_gnt    = if_win;
        d_gnt     = d_win;
        mem_en    = if_win || d_win;
        mem_we    = d_win && d_we;
        mem_addr  = d_win ? d_addr : (if_win ? if_addr : '0);
        mem_wdata = (d_win && d_we) ? d_wdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [15:0] conflict_q, conflict_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        conflict_d = conflict_q;
        stall_d    = stall_q;
        if (slot_free && if_req && d_req && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
        if (if_req && !if_win && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_q <= '0;
            stall_q    <= '0;
        end else begin
            conflict_q <= conflict_d;
            stall_q    <= stall_d;
        end
    end

    assign conflict_cnt    = conflict_q;
    assign fetch_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: dut A at MEM_LATENCY=1, dut B at MEM_LATENCY=3,
// each against a behavioural memory, with a response scoreboard per port.
module tb_mem_port_arbiter;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic        a_rst, a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        b_rst, b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [15:0] a_conflict, a_stall, b_conflict, b_stall;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut_a (
        .clk(clk), .reset(a_rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
`ifdef MEM_PORT_ARBITER_PERF_EN
        , .conflict_cnt(a_conflict), .fetch_stall_cnt(a_stall)
`endif
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut_b (
        .clk(clk), .reset(b_rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
`ifdef MEM_PORT_ARBITER_PERF_EN
        , .conflict_cnt(b_conflict), .fetch_stall_cnt(b_stall)
`endif
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hC0DE_0000 | 32'(i * 4);
    endfunction

    // Behavioural memories: contents loaded on the first clock, reads delayed by latency.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] rd_a;
    logic [31:0] rd_b [3];
    bit          loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
            loaded <= 1'b1;
        end else begin
            if (a_mem_en && a_mem_we) mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
            if (b_mem_en && b_mem_we) mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
        end
        rd_a    <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr[9:2]] : 32'h0;
        rd_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[9:2]] : 32'h0;
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end
    assign a_mem_rdata = rd_a;
    assign b_mem_rdata = rd_b[2];

    exp_t a_ifq[$], a_dq[$], b_ifq[$], b_dq[$];

    always @(negedge clk) begin
        exp_t e;
        if (!a_rst) begin
            a_ifq.delete();
            a_dq.delete();
        end else begin
            if (a_if_rvalid) begin
                n_checks++;
                if (a_ifq.size() == 0) $display("FAIL a_if_resp: unexpected rvalid cycle %0d data %h, required none", cyc, a_if_rdata);
                else begin
                    e = a_ifq.pop_front();
                    if (cyc !== e.cyc || a_if_rdata !== e.data)
                        $display("FAIL a_if_resp: cycle %0d data %h, required cycle %0d data %h", cyc, a_if_rdata, e.cyc, e.data);
                    else n_pass++;
                end
            end
            if (a_d_rvalid) begin
                n_checks++;
                if (a_dq.size() == 0) $display("FAIL a_d_resp: unexpected rvalid cycle %0d data %h, required none", cyc, a_d_rdata);
                else begin
                    e = a_dq.pop_front();
                    if (cyc !== e.cyc || a_d_rdata !== e.data)
                        $display("FAIL a_d_resp: cycle %0d data %h, required cycle %0d data %h", cyc, a_d_rdata, e.cyc, e.data);
                    else n_pass++;
                end
            end
            if (a_if_gnt) a_ifq.push_back('{cyc + 1, mem_a[a_if_addr[9:2]]});
            if (a_d_gnt && !a_d_we) a_dq.push_back('{cyc + 1, mem_a[a_d_addr[9:2]]});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!b_rst) begin
            b_ifq.delete();
            b_dq.delete();
        end else begin
            if (b_if_rvalid) begin
                n_checks++;
                if (b_ifq.size() == 0) $display("FAIL b_if_resp: unexpected rvalid cycle %0d data %h, required none", cyc, b_if_rdata);
                else begin
                    e = b_ifq.pop_front();
                    if (cyc !== e.cyc || b_if_rdata !== e.data)
                        $display("FAIL b_if_resp: cycle %0d data %h, required cycle %0d data %h", cyc, b_if_rdata, e.cyc, e.data);
                    else n_pass++;
                end
            end
            if (b_d_rvalid) begin
                n_checks++;
                if (b_dq.size() == 0) $display("FAIL b_d_resp: unexpected rvalid cycle %0d data %h, required none", cyc, b_d_rdata);
                else begin
                    e = b_dq.pop_front();
                    if (cyc !== e.cyc || b_d_rdata !== e.data)
                        $display("FAIL b_d_resp: cycle %0d data %h, required cycle %0d data %h", cyc, b_d_rdata, e.cyc, e.data);
                    else n_pass++;
                end
            end
            if (b_if_gnt) b_ifq.push_back('{cyc + 3, mem_b[b_if_addr[9:2]]});
            if (b_d_gnt && !b_d_we) b_dq.push_back('{cyc + 3, mem_b[b_d_addr[9:2]]});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b0; b_rst = 1'b0;
        a_if_req = 1'b1; a_if_addr = 32'h4; a_d_req = 1'b1; a_d_we = 1'b1;
        a_d_addr = 32'h8; a_d_wdata = 32'h1234_5678;
        b_if_req = 1'b1; b_if_addr = 32'h4; b_d_req = 1'b1; b_d_we = 1'b0;
        b_d_addr = 32'h8; b_d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_mem_en, a_mem_we} !== 6'b0)
            $display("FAIL reset_a_ctrl: got %b, required 000000", {a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_mem_en, a_mem_we});
        else n_pass++;
        n_checks++;
        if ({b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_mem_we} !== 6'b0)
            $display("FAIL reset_b_ctrl: got %b, required 000000", {b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_mem_we});
        else n_pass++;
        n_checks++;
        if ({a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata} !== 128'h0)
            $display("FAIL reset_a_data: got %h, required 0", {a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata});
        else n_pass++;
        n_checks++;
        if ({b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata} !== 128'h0)
            $display("FAIL reset_b_data: got %h, required 0", {b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata});
        else n_pass++;
        next_cycle();
        a_if_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0;
        b_if_req = 1'b0; b_d_req = 1'b0;
        a_rst = 1'b1; b_rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_fetch_only();
        for (int k = 0; k < 3; k++) begin
            a_if_req = 1'b1;
            a_if_addr = 32'(k * 4);
            @(negedge clk);
            n_checks++;
            if (a_if_gnt !== 1'b1 || a_d_gnt !== 1'b0 || a_mem_addr !== 32'(k * 4) || a_mem_we !== 1'b0)
                $display("FAIL fetch_gnt%0d: gnt %b/%b addr %h we %b, required 1/0 %h 0", k, a_if_gnt, a_d_gnt, a_mem_addr, a_mem_we, 32'(k * 4));
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if (a_if_rvalid !== 1'b1 || a_if_rdata !== (32'hC0DE_0000 | 32'((k - 1) * 4)))
                    $display("FAIL fetch_data%0d: rvalid %b data %h, required 1 %h", k, a_if_rvalid, a_if_rdata, 32'hC0DE_0000 | 32'((k - 1) * 4));
                else n_pass++;
            end
            next_cycle();
        end
        a_if_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_if_rvalid !== 1'b1 || a_if_rdata !== 32'hC0DE_0008 || a_d_rvalid !== 1'b0)
            $display("FAIL fetch_last: rvalid %b data %h d_rvalid %b, required 1 c0de0008 0", a_if_rvalid, a_if_rdata, a_d_rvalid);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_starve();
        logic exp_if;
        a_if_req = 1'b1; a_if_addr = 32'h10;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_if = ((i % 5) == 4);
            n_checks++;
            if ({a_if_gnt, a_d_gnt} !== {exp_if, !exp_if})
                $display("FAIL starve_order%0d: if/d gnt %b%b, required %b%b", i, a_if_gnt, a_d_gnt, exp_if, !exp_if);
            else n_pass++;
            next_cycle();
        end
        a_if_req = 1'b0; a_d_req = 1'b0;
        next_cycle();
    endtask

`ifdef MEM_PORT_ARBITER_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        n_checks++;
        if (a_conflict !== 16'd10 || a_stall !== 16'd8)
            $display("FAIL perf_cnt: conflict %0d stall %0d, required 10 8", a_conflict, a_stall);
        else n_pass++;
        next_cycle();
    endtask
`endif

    task automatic test_latency3();
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h100;
        b_if_req = 1'b1; b_if_addr = 32'h0;
        @(negedge clk);
        n_checks++;
        if (b_d_gnt !== 1'b1 || b_if_gnt !== 1'b0)
            $display("FAIL lat3_t0: d/if gnt %b%b, required 10", b_d_gnt, b_if_gnt);
        else n_pass++;
        next_cycle();
        b_d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b_d_gnt !== 1'b0 || b_if_gnt !== 1'b0 || b_mem_en !== 1'b0)
            $display("FAIL lat3_t1: d/if gnt %b%b mem_en %b, required 000", b_d_gnt, b_if_gnt, b_mem_en);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (b_if_gnt !== 1'b1 || b_mem_addr !== 32'h0)
            $display("FAIL lat3_t2: if_gnt %b addr %h, required 1 0", b_if_gnt, b_mem_addr);
        else n_pass++;
        next_cycle();
        b_if_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b_d_rvalid !== 1'b1 || b_d_rdata !== 32'hC0DE_0100)
            $display("FAIL lat3_t3: d_rvalid %b data %h, required 1 c0de0100", b_d_rvalid, b_d_rdata);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (b_d_rvalid !== 1'b0 || b_d_rdata !== 32'hC0DE_0100 || b_if_rvalid !== 1'b0)
            $display("FAIL lat3_hold: d_rvalid %b data %h if_rvalid %b, required 0 c0de0100 0", b_d_rvalid, b_d_rdata, b_if_rvalid);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (b_if_rvalid !== 1'b1 || b_if_rdata !== 32'hC0DE_0000)
            $display("FAIL lat3_t5: if_rvalid %b data %h, required 1 c0de0000", b_if_rvalid, b_if_rdata);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_store_load();
        int t_store, t_load, t_rv;
        bit got;
        b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 32'h40; b_d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        t_store = cyc;
        n_checks++;
        if (b_d_gnt !== 1'b1 || b_mem_en !== 1'b1 || b_mem_we !== 1'b1 || b_mem_addr !== 32'h40 || b_mem_wdata !== 32'hDEAD_BEEF)
            $display("FAIL store_gnt: gnt %b en %b we %b addr %h wdata %h, required 1 1 1 40 deadbeef", b_d_gnt, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata);
        else n_pass++;
        next_cycle();
        b_d_we = 1'b0; b_d_wdata = 32'h0;
        got = 1'b0; t_load = -1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (b_d_gnt === 1'b1) begin
                got = 1'b1;
                t_load = cyc;
                n_checks++;
                if (b_mem_we !== 1'b0) $display("FAIL load_we: mem_we %b, required 0", b_mem_we);
                else n_pass++;
            end
            next_cycle();
            if (got) b_d_req = 1'b0;
        end
        n_checks++;
        if (t_load !== t_store + 2) $display("FAIL load_gnt_cycle: %0d, required %0d", t_load, t_store + 2);
        else n_pass++;
        b_d_req = 1'b0;
        got = 1'b0; t_rv = -1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (b_d_rvalid === 1'b1) begin
                got = 1'b1;
                t_rv = cyc;
                n_checks++;
                if (b_d_rdata !== 32'hDEAD_BEEF) $display("FAIL load_data: %h, required deadbeef", b_d_rdata);
                else n_pass++;
            end
            next_cycle();
        end
        n_checks++;
        if (t_rv !== t_load + 3) $display("FAIL load_rvalid_cycle: %0d, required %0d", t_rv, t_load + 3);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h100;
        @(negedge clk);
        n_checks++;
        if (b_d_gnt !== 1'b1) $display("FAIL rst_mid_gnt: %b, required 1", b_d_gnt);
        else n_pass++;
        next_cycle();
        b_d_req = 1'b0;
        #2 b_rst = 1'b0;
        #1;
        n_checks++;
        if ({b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_mem_we} !== 6'b0 || b_d_rdata !== 32'h0 || b_if_rdata !== 32'h0)
            $display("FAIL rst_mid_outputs: ctrl %b d_rdata %h if_rdata %h, required 000000 0 0",
                     {b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_mem_we}, b_d_rdata, b_if_rdata);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        b_rst = 1'b1;
        b_d_req = 1'b1; b_d_addr = 32'h8;
        @(negedge clk);
        n_checks++;
        if (b_d_gnt !== 1'b1 || b_d_rvalid !== 1'b0)
            $display("FAIL rst_release: gnt %b rvalid %b, required 1 0", b_d_gnt, b_d_rvalid);
        else n_pass++;
        next_cycle();
        b_d_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (b_d_rvalid !== (k == 3) || (k == 3 && b_d_rdata !== 32'hC0DE_0008))
                $display("FAIL rst_after%0d: rvalid %b data %h, required %b c0de0008", k, b_d_rvalid, b_d_rdata, (k == 3));
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_drain();
        repeat (4) next_cycle();
        @(negedge clk);
        n_checks++;
        if (a_ifq.size() + a_dq.size() + b_ifq.size() + b_dq.size() != 0)
            $display("FAIL drain: %0d responses outstanding, required 0", a_ifq.size() + a_dq.size() + b_ifq.size() + b_dq.size());
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_only();
        test_starve();
`ifdef MEM_PORT_ARBITER_PERF_EN
        test_perf();
`endif
        test_latency3();
        test_store_load();
        test_reset_midflight();
        test_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
